core_l1d_bridge: RTL

Bridges the pipeline's L1 data request/ack interface to a word-wide ready/valid memory port. It sits directly downstream of the pipeline's memory stage, which issues `l1d_req_*` and waits for `l1d_ack_*`. The bridge handles one outstanding transaction at a time:

- checks alignment and size;
- generates byte enables and lane-replicated write data;
- right-aligns read data;
- converts a missing memory response into an error ack after a timeout.

---
 rtl/core_l1d_bridge.sv | 133 +++++++++++++
 1 files changed

// File: rtl/core_l1d_bridge.sv
// core_l1d_bridge: L1D request/ack to word-wide ready/valid memory port bridge
module core_l1d_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        l1d_req_val_in,
  input  logic [31:0] l1d_req_addr_in,
  input  logic [2:0]  l1d_req_cop_in,
  input  logic [31:0] l1d_req_wdata_in,
  input  logic [2:0]  l1d_req_size_in,
  output logic        l1d_ack_ack_out,
  output logic [31:0] l1d_ack_rdata_out,
  output logic        l1d_err_out,
  output logic        l1d_busy_out,
  output logic        mem_req_val_out,
  input  logic        mem_req_rdy_in,
  output logic [31:0] mem_req_addr_out,
  output logic        mem_req_we_out,
  output logic [3:0]  mem_req_be_out,
  output logic [31:0] mem_req_wdata_out,
  input  logic        mem_ack_val_in,
  input  logic [31:0] mem_ack_rdata_in
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  off;
  logic [2:0]  size;
  logic        we;
  logic        unused_unc_q;
  logic        unused_cop;
  logic [1:0]  in_off;
  logic        legal;
  logic        tmo;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] rd_shift;
  logic [31:0] rd_c;

  assign unused_cop = l1d_req_cop_in[2];
  assign in_off     = l1d_req_addr_in[1:0];

  // Request legality, lane mapping of the incoming request and read-data alignment
  always_comb begin
    legal    = (l1d_req_size_in == 3'b000) ||
               (l1d_req_size_in == 3'b001 && !in_off[0]) ||
               (l1d_req_size_in == 3'b010 && in_off == 2'b00);
    be_c     = (l1d_req_size_in == 3'b000) ? 4'b0001 << in_off :
               (l1d_req_size_in == 3'b001) ? 4'b0011 << in_off : 4'b1111;
    wd_c     = (l1d_req_size_in == 3'b000) ? {4{l1d_req_wdata_in[7:0]}} :
               (l1d_req_size_in == 3'b001) ? {2{l1d_req_wdata_in[15:0]}} : l1d_req_wdata_in;
    rd_shift = mem_ack_rdata_in >> {off, 3'b000};
    rd_c     = (size == 3'b000) ? {24'b0, rd_shift[7:0]} :
               (size == 3'b001) ? {16'b0, rd_shift[15:0]} : rd_shift;
    tmo      = ({1'b0, cnt} + 17'd1) == 17'(TIMEOUT_CYCLES);
  end

  // Transaction FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      off               <= '0;
      size              <= '0;
      we                <= 1'b0;
      unused_unc_q      <= 1'b0;
      l1d_ack_ack_out   <= 1'b0;
      l1d_ack_rdata_out <= '0;
      l1d_err_out       <= 1'b0;
      l1d_busy_out      <= 1'b0;
      mem_req_val_out   <= 1'b0;
      mem_req_addr_out  <= '0;
      mem_req_we_out    <= 1'b0;
      mem_req_be_out    <= '0;
      mem_req_wdata_out <= '0;
    end else begin
      l1d_ack_ack_out   <= 1'b0;
      l1d_err_out       <= 1'b0;
      l1d_ack_rdata_out <= '0;
      case (state)
        IDLE: if (l1d_req_val_in) begin
          off          <= in_off;
          size         <= l1d_req_size_in;
          we           <= l1d_req_cop_in[0];
          unused_unc_q <= l1d_req_cop_in[1];
          cnt          <= '0;
          l1d_busy_out <= 1'b1;
          if (legal) begin
            state             <= REQ;
            mem_req_val_out   <= 1'b1;
            mem_req_addr_out  <= {l1d_req_addr_in[31:2], 2'b00};
            mem_req_we_out    <= l1d_req_cop_in[0];
            mem_req_be_out    <= be_c;
            mem_req_wdata_out <= wd_c;
          end else begin
            state           <= RESP;
            l1d_ack_ack_out <= 1'b1;
            l1d_err_out     <= 1'b1;
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (tmo) begin
            state           <= RESP;
            mem_req_val_out <= 1'b0;
            l1d_ack_ack_out <= 1'b1;
            l1d_err_out     <= 1'b1;
          end else if (mem_req_rdy_in) begin
            state           <= WAIT;
            mem_req_val_out <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (tmo) begin
            state           <= RESP;
            l1d_ack_ack_out <= 1'b1;
            l1d_err_out     <= 1'b1;
          end else if (mem_ack_val_in) begin
            state             <= RESP;
            l1d_ack_ack_out   <= 1'b1;
            l1d_ack_rdata_out <= we ? 32'b0 : rd_c;
          end
        end
        default: begin
          state        <= IDLE;
          l1d_busy_out <= 1'b0;
        end
      endcase
    end
  end
endmodule
